// File: rtl/risc_pc_unit.sv
// risc_pc_unit
// ------------
// Program-counter unit for the RISC-V core. Holds the fetch address and
// computes the next one for sequential flow, PC-relative branch/JAL and
// register-indirect JALR. Also handles single-level trap entry/return with
// EPC save and MRET, misaligned-target detection, and a HALT state that is
// entered on any fault taken while already in a trap.
//
// Ports
//   clk            in   rising-edge system clock
//   reset          in   asynchronous, active-low reset
//   load           in   advance enable (trap_req is honoured regardless)
//   pcSrc          in   00 pc+STEP, 01 pc+immExt, 10 (rs1+immExt)&~1, 11 as 00
//   immExt         in   sign-extended immediate
//   rs1            in   JALR base register value
//   trap_req       in   external trap request, sampled every cycle
//   mret           in   return-from-trap request, qualified by load
//   pc             out  current fetch address (registered)
//   pc_plus_step   out  pc+STEP, combinational (link value)
//   epc            out  saved exception PC (registered)
//   trap_cause     out  00 none, 01 external, 10 misaligned target
//   in_trap        out  1 while in TRAP
//   halted         out  1 while in HALT
//   misalign_fault out  one-cycle registered pulse on a misaligned target
module risc_pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              ALIGN_BITS   = 2,
    parameter int              STEP         = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [1:0]      pcSrc,
    input  logic [XLEN-1:0] immExt,
    input  logic [XLEN-1:0] rs1,
    input  logic            trap_req,
    input  logic            mret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus_step,
    output logic [XLEN-1:0] epc,
    output logic [1:0]      trap_cause,
    output logic            in_trap,
    output logic            halted,
    output logic            misalign_fault
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_EXTERNAL = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

    // Low PC bits that must be zero for a legal branch/jump target.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
    localparam logic [XLEN-1:0] BIT0_CLEAR = ~XLEN'(1);

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic [1:0]      cause_q;
    logic            fault_q;

    logic [XLEN-1:0] seq_d;
    logic [XLEN-1:0] tgt_d;
    logic            misaligned_d;

    // Next-address selection. Sums wrap modulo 2^XLEN by construction.
    always_comb begin
        seq_d = pc_q + STEP_X;
        tgt_d = seq_d;
        misaligned_d = 1'b0;
        case (pcSrc)
            2'b01: begin
                tgt_d        = pc_q + immExt;
                misaligned_d = |(tgt_d & ALIGN_MASK);
            end
            2'b10: begin
                tgt_d        = (rs1 + immExt) & BIT0_CLEAR;
                misaligned_d = |(tgt_d & ALIGN_MASK);
            end
            default: begin
                tgt_d        = seq_d;
                misaligned_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cause_q <= CAUSE_NONE;
            fault_q <= 1'b0;
        end else begin
            // The fault flag is a pulse: it is only high for the cycle
            // following the edge that detected the misaligned target.
            fault_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (trap_req) begin
                        epc_q   <= pc_q;
                        pc_q    <= TRAP_VECTOR;
                        cause_q <= CAUSE_EXTERNAL;
                        state_q <= ST_TRAP;
                    end else if (load) begin
                        if (misaligned_d) begin
                            // The bad target is discarded; the faulting PC is saved.
                            epc_q   <= pc_q;
                            pc_q    <= TRAP_VECTOR;
                            cause_q <= CAUSE_MISALIGN;
                            fault_q <= 1'b1;
                            state_q <= ST_TRAP;
                        end else begin
                            // mret outside a trap is a plain advance.
                            pc_q <= tgt_d;
                        end
                    end
                end
                ST_TRAP: begin
                    if (trap_req) begin
                        // No nesting: a second fault stops the core.
                        state_q <= ST_HALT;
                    end else if (load) begin
                        if (mret) begin
                            // Return uses epc, not the computed target, so the
                            // pcSrc alignment check does not apply here.
                            pc_q    <= epc_q;
                            state_q <= ST_RUN;
                        end else if (misaligned_d) begin
                            fault_q <= 1'b1;
                            state_q <= ST_HALT;
                        end else begin
                            pc_q <= tgt_d;
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign pc             = pc_q;
    assign pc_plus_step   = seq_d;
    assign epc            = epc_q;
    assign trap_cause     = cause_q;
    assign in_trap        = (state_q == ST_TRAP);
    assign halted         = (state_q == ST_HALT);
    assign misalign_fault = fault_q;

endmodule
